// File: rtl/decode_pipe.sv
// Decode stage of a Y86-64 style pipeline: source/destination selection,
// operand forwarding, the register file and the D->E pipeline register.
module decode_pipe #(
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [3:0] RSP_ID   = 4'h4,
  parameter logic [3:0] STAT_AOK = 4'h1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               E_bubble,
  input  logic [3:0]         D_icode,
  input  logic [3:0]         D_ifun,
  input  logic [3:0]         D_rA,
  input  logic [3:0]         D_rB,
  input  logic signed [63:0] D_valC,
  input  logic signed [63:0] D_valP,
  input  logic [3:0]         D_stat,
  input  logic [3:0]         e_dstE,
  input  logic signed [63:0] e_valE,
  input  logic [3:0]         M_dstE,
  input  logic [3:0]         M_dstM,
  input  logic signed [63:0] M_valE,
  input  logic signed [63:0] m_valM,
  input  logic [3:0]         W_dstE,
  input  logic [3:0]         W_dstM,
  input  logic signed [63:0] W_valE,
  input  logic signed [63:0] W_valM,
  input  logic [3:0]         W_icode,
  output logic [3:0]         E_icode,
  output logic [3:0]         E_ifun,
  output logic [3:0]         E_dstE,
  output logic [3:0]         E_dstM,
  output logic [3:0]         E_srcA,
  output logic [3:0]         E_srcB,
  output logic signed [63:0] E_valC,
  output logic signed [63:0] E_valA,
  output logic signed [63:0] E_valB,
  output logic [3:0]         E_stat,
  output logic [3:0]         d_srcA,
  output logic [3:0]         d_srcB,
  output logic signed [63:0] rax, rbx, rcx, rdx, rsp, rbp, rsi, rbi,
  output logic signed [63:0] r8, r9, r10, r11, r12, r13, r14
);

  typedef enum logic [3:0] {
    I_HALT  = 4'h0, I_NOP   = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3,
    I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OP   = 4'h6, I_JXX   = 4'h7,
    I_CALL  = 4'h8, I_RET   = 4'h9, I_PUSH = 4'hA, I_POP   = 4'hB
  } icode_e;

  icode_e             icode;
  logic [3:0]         d_dstE, d_dstM;
  logic signed [63:0] rf [15];
  logic signed [63:0] rf_a, rf_b, d_valA, d_valB;
  logic               unused_w_icode;

  assign icode          = icode_e'(D_icode);
  assign unused_w_icode = ^W_icode;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (icode)
      I_CMOV, I_RMMOV, I_OP, I_PUSH: d_srcA = D_rA;
      I_RET, I_POP:                  d_srcA = RSP_ID;
      default: ;
    endcase
    case (icode)
      I_RMMOV, I_MRMOV, I_OP:        d_srcB = D_rB;
      I_CALL, I_RET, I_PUSH, I_POP:  d_srcB = RSP_ID;
      default: ;
    endcase
    case (icode)
      I_CMOV, I_IRMOV, I_OP:         d_dstE = D_rB;
      I_CALL, I_RET, I_PUSH, I_POP:  d_dstE = RSP_ID;
      default: ;
    endcase
    case (icode)
      I_MRMOV, I_POP:                d_dstM = D_rA;
      default: ;
    endcase
  end

  // IDs outside 0..14 never match, so RNONE reads as zero
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (d_srcA == 4'(i)) rf_a = rf[i];
      if (d_srcB == 4'(i)) rf_b = rf[i];
    end
  end

  function automatic logic signed [63:0] fwd(input logic [3:0] src,
                                             input logic signed [63:0] rf_val);
    if (src == RNONE)       return '0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_val;
  endfunction

  always_comb begin
    d_valA = fwd(d_srcA, rf_a);
    d_valB = fwd(d_srcB, rf_b);
    if (icode == I_JXX || icode == I_CALL) d_valA = D_valP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_stat  <= STAT_AOK;
    end else begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_stat  <= D_stat;
    end
  end

  // Memory-port write is checked first so it wins when both ports target one register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 15; i++) begin
        if (W_dstM != RNONE && W_dstM == 4'(i))      rf[i] <= W_valM;
        else if (W_dstE != RNONE && W_dstE == 4'(i)) rf[i] <= W_valE;
      end
    end
  end

  assign rax = rf[0];
  assign rbx = rf[1];
  assign rcx = rf[2];
  assign rdx = rf[3];
  assign rsp = rf[4];
  assign rbp = rf[5];
  assign rsi = rf[6];
  assign rbi = rf[7];
  assign r8  = rf[8];
  assign r9  = rf[9];
  assign r10 = rf[10];
  assign r11 = rf[11];
  assign r12 = rf[12];
  assign r13 = rf[13];
  assign r14 = rf[14];

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: decode table, directed pipeline scenarios and a
// randomized run against a register-array reference model.
module tb_decode_pipe;
  localparam logic [3:0] RN = 4'hF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic E_bubble;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic signed [63:0] D_valC, D_valP;
  logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, W_icode;
  logic signed [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0] E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_stat;
  logic [3:0] d_srcA, d_srcB;
  logic signed [63:0] E_valC, E_valA, E_valB;
  logic signed [63:0] r [15];

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] mreg [15];

  always #5 clk = ~clk;

  decode_pipe #(.RNONE(4'hF), .RSP_ID(4'h4), .STAT_AOK(4'h1)) dut (
    .clk(clk), .rst_n(rst_n), .E_bubble(E_bubble),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .W_icode(W_icode),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valC(E_valC), .E_valA(E_valA),
    .E_valB(E_valB), .E_stat(E_stat), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .rax(r[0]), .rbx(r[1]), .rcx(r[2]), .rdx(r[3]), .rsp(r[4]), .rbp(r[5]),
    .rsi(r[6]), .rbi(r[7]), .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14])
  );

  typedef struct {
    logic [3:0]  icode, rA, rB;
    logic [63:0] valP;
    logic        bubble;
    logic [3:0]  srcA, srcB, dstE, dstM, eicode;
    logic [63:0] valA;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = RN; D_rB = RN; D_stat = 4'h1;
    D_valC = '0; D_valP = '0;
    e_dstE = RN; M_dstE = RN; M_dstM = RN; W_dstE = RN; W_dstM = RN;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    W_icode = 4'h1; E_bubble = 1'b0;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".E_icode"}, E_icode, 4'h1);
    chk({tag, ".E_ifun"},  E_ifun,  4'h0);
    chk({tag, ".E_dstE"},  E_dstE,  RN);
    chk({tag, ".E_dstM"},  E_dstM,  RN);
    chk({tag, ".E_srcA"},  E_srcA,  RN);
    chk({tag, ".E_srcB"},  E_srcB,  RN);
    chk({tag, ".E_valC"},  E_valC,  64'd0);
    chk({tag, ".E_valA"},  E_valA,  64'd0);
    chk({tag, ".E_valB"},  E_valB,  64'd0);
    chk({tag, ".E_stat"},  E_stat,  4'h1);
  endtask

  task automatic chk_regs_zero(input string tag);
    for (int i = 0; i < 15; i++) chk($sformatf("%s.reg%0d", tag, i), r[i], 64'd0);
  endtask

  // Reference model: instruction-class membership and an ordered forwarding scan
  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return RN;
  endfunction
  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return RN;
  endfunction
  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return RN;
  endfunction
  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return RN;
  endfunction
  function automatic logic [63:0] m_val(input logic [3:0] src);
    logic [3:0]  d [5];
    logic [63:0] v [5];
    if (src == RN) return 64'd0;
    d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    for (int i = 0; i < 5; i++) if (d[i] == src) return v[i];
    return mreg[src];
  endfunction

  function automatic logic [3:0] rid();
    if ($urandom_range(0, 3) == 0) return RN;
    return 4'($urandom_range(0, 6));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB, x_stat;
    logic [63:0] x_valC, x_valA, x_valB;
    logic        x_bub;
    logic [63:0] want [15];

    // rA=2 rB=3, empty register file, no forwarding sources
    tbl.push_back('{4'h0, 4'h2, 4'h3, 64'h55, 1'b0, RN,   RN,   RN,   RN,   4'h0, 64'h0});
    tbl.push_back('{4'h1, 4'h2, 4'h3, 64'h55, 1'b0, RN,   RN,   RN,   RN,   4'h1, 64'h0});
    tbl.push_back('{4'h2, 4'h2, 4'h3, 64'h55, 1'b0, 4'h2, RN,   4'h3, RN,   4'h2, 64'h0});
    tbl.push_back('{4'h3, 4'h2, 4'h3, 64'h55, 1'b0, RN,   RN,   4'h3, RN,   4'h3, 64'h0});
    tbl.push_back('{4'h4, 4'h2, 4'h3, 64'h55, 1'b0, 4'h2, 4'h3, RN,   RN,   4'h4, 64'h0});
    tbl.push_back('{4'h5, 4'h2, 4'h3, 64'h55, 1'b0, RN,   4'h3, RN,   4'h2, 4'h5, 64'h0});
    tbl.push_back('{4'h6, 4'h2, 4'h3, 64'h55, 1'b0, 4'h2, 4'h3, 4'h3, RN,   4'h6, 64'h0});
    tbl.push_back('{4'h7, 4'h2, 4'h3, 64'h55, 1'b0, RN,   RN,   RN,   RN,   4'h7, 64'h55});
    tbl.push_back('{4'h8, 4'h2, 4'h3, 64'h55, 1'b0, RN,   4'h4, 4'h4, RN,   4'h8, 64'h55});
    tbl.push_back('{4'h9, 4'h2, 4'h3, 64'h55, 1'b0, 4'h4, 4'h4, 4'h4, RN,   4'h9, 64'h0});
    tbl.push_back('{4'hA, 4'h2, 4'h3, 64'h55, 1'b0, 4'h2, 4'h4, 4'h4, RN,   4'hA, 64'h0});
    tbl.push_back('{4'hB, 4'h2, 4'h3, 64'h55, 1'b0, 4'h4, 4'h4, 4'h4, 4'h2, 4'hB, 64'h0});
    tbl.push_back('{4'h6, 4'h2, 4'h3, 64'h55, 1'b1, 4'h2, 4'h3, RN,   RN,   4'h1, 64'h0});

    idle();
    rst_n = 1'b0;
    #12;
    chk_bubble("reset");
    chk_regs_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[k]) begin
      D_icode = tbl[k].icode; D_rA = tbl[k].rA; D_rB = tbl[k].rB;
      D_valP = tbl[k].valP; E_bubble = tbl[k].bubble;
      #1;
      chk($sformatf("tbl%0d.d_srcA", k), d_srcA, tbl[k].srcA);
      chk($sformatf("tbl%0d.d_srcB", k), d_srcB, tbl[k].srcB);
      tick();
      chk($sformatf("tbl%0d.E_icode", k), E_icode, tbl[k].eicode);
      chk($sformatf("tbl%0d.E_dstE", k), E_dstE, tbl[k].dstE);
      chk($sformatf("tbl%0d.E_dstM", k), E_dstM, tbl[k].dstM);
      chk($sformatf("tbl%0d.E_srcA", k), E_srcA, tbl[k].bubble ? RN : tbl[k].srcA);
      chk($sformatf("tbl%0d.E_valA", k), E_valA, tbl[k].valA);
    end
    idle();

    W_dstE = 4'h0; W_valE = 64'd10; tick();
    chk("wb.rax", r[0], 64'd10);
    W_dstE = RN; W_dstM = 4'h3; W_valM = 64'd7; tick();
    chk("wb.rdx", r[3], 64'd7);
    chk("wb.rax_hold", r[0], 64'd10);
    W_dstE = 4'h4; W_dstM = 4'h4; W_valE = 64'd1; W_valM = 64'd2; tick();
    chk("wb.rsp_valM_wins", r[4], 64'd2);
    idle();

    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
    e_dstE = 4'h2; e_valE = 64'd5; M_dstE = 4'h2; M_valE = 64'd6;
    M_dstM = 4'h3; m_valM = 64'd9;
    tick();
    chk("fwd.E_valA", E_valA, 64'd5);
    chk("fwd.E_valB", E_valB, 64'd9);
    chk("fwd.E_srcA", E_srcA, 4'h2);
    chk("fwd.E_dstE", E_dstE, 4'h3);
    e_dstE = RN; tick();
    chk("fwd2.E_valA", E_valA, 64'd6);
    idle();

    W_dstE = 4'h4; W_valE = 64'h100; tick();
    idle();
    D_icode = 4'h8; D_valP = 64'h20;
    #1;
    chk("call.d_srcA", d_srcA, RN);
    chk("call.d_srcB", d_srcB, 4'h4);
    tick();
    chk("call.E_valA", E_valA, 64'h20);
    chk("call.E_valB", E_valB, 64'h100);
    chk("call.E_dstE", E_dstE, 4'h4);
    idle();

    D_icode = 4'hB; D_rA = 4'h1;
    #1;
    chk("pop.d_srcA", d_srcA, 4'h4);
    chk("pop.d_srcB", d_srcB, 4'h4);
    tick();
    chk("pop.E_dstE", E_dstE, 4'h4);
    chk("pop.E_dstM", E_dstM, 4'h1);
    chk("pop.E_valA", E_valA, 64'h100);
    idle();

    D_icode = 4'h3; D_rB = 4'h5; D_valC = 64'h77; E_bubble = 1'b1;
    tick();
    chk_bubble("bubble");
    for (int i = 0; i < 15; i++) want[i] = 64'd0;
    want[0] = 64'd10; want[3] = 64'd7; want[4] = 64'h100;
    for (int i = 0; i < 15; i++) chk($sformatf("bubble.reg%0d", i), r[i], want[i]);
    idle();

    // Asynchronous reset between edges with a write pending
    W_dstE = 4'h0; W_valE = 64'd99; D_icode = 4'h6; D_rA = 4'h0; D_rB = 4'h3;
    #2 rst_n = 1'b0;
    #1;
    chk_bubble("async");
    chk_regs_zero("async");
    tick();
    chk("async.rax_held", r[0], 64'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    W_dstE = 4'h1; W_valE = 64'h33;
    tick();
    chk("resume.rax", r[0], 64'd0);
    chk("resume.rbx", r[1], 64'h33);
    idle();

    for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
    mreg[1] = 64'h33;

    for (int c = 0; c < 400; c++) begin
      D_icode = 4'($urandom_range(0, 11)); D_ifun = 4'($urandom);
      D_rA = rid(); D_rB = rid(); D_stat = 4'($urandom);
      D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
      e_dstE = rid(); M_dstE = rid(); M_dstM = rid(); W_dstE = rid(); W_dstM = rid();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
      W_valM = {$urandom, $urandom}; W_icode = 4'($urandom);
      x_bub = ($urandom_range(0, 4) == 0);
      E_bubble = x_bub;

      x_srcA = m_srcA(D_icode, D_rA);
      x_srcB = m_srcB(D_icode, D_rB);
      x_dstE = m_dstE(D_icode, D_rB);
      x_dstM = m_dstM(D_icode, D_rA);
      x_valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_val(x_srcA);
      x_valB = m_val(x_srcB);
      x_icode = D_icode; x_ifun = D_ifun; x_valC = D_valC; x_stat = D_stat;
      #1;
      chk("rnd.d_srcA", d_srcA, x_srcA);
      chk("rnd.d_srcB", d_srcB, x_srcB);
      tick();
      if (W_dstE != RN) mreg[W_dstE] = W_valE;
      if (W_dstM != RN) mreg[W_dstM] = W_valM;
      if (x_bub) begin
        chk_bubble("rnd_bub");
      end else begin
        chk("rnd.E_icode", E_icode, x_icode);
        chk("rnd.E_ifun", E_ifun, x_ifun);
        chk("rnd.E_dstE", E_dstE, x_dstE);
        chk("rnd.E_dstM", E_dstM, x_dstM);
        chk("rnd.E_srcA", E_srcA, x_srcA);
        chk("rnd.E_srcB", E_srcB, x_srcB);
        chk("rnd.E_valC", E_valC, x_valC);
        chk("rnd.E_valA", E_valA, x_valA);
        chk("rnd.E_valB", E_valB, x_valB);
        chk("rnd.E_stat", E_stat, x_stat);
      end
      for (int i = 0; i < 15; i++) chk($sformatf("rnd.reg%0d", i), r[i], mreg[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
